// File: rtl/fetch_queue_pkg.sv
// fetch_pkg: shared types for the instruction fetch front end.
// XLEN, FSM state encoding, prefetch queue entry, default reset PC.
package fetch_pkg;

  localparam int XLEN = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_queue_inst_fifo.sv
// inst_fifo: synchronous prefetch FIFO of {pc, inst} entries.
// Ports: clk, rst, flush, push/wr_data, pop/rd_data, count.
module inst_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     wr_data,
  input  logic             pop,
  output fetch_entry_t     rd_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != FULL) | do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch FSM, fetch_pc and redirect/drop handling.
// Ports: clk, rst; imem_req/addr/ack/rdata; redirect/redirect_pc, stall;
//        inst_valid/inst_out/inst_pc toward decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [15:0] inst_out,
  output logic [15:0] inst_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_state_t     state;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  req_addr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] post_cnt;
  fetch_entry_t     wr_entry;
  fetch_entry_t     head;
  logic             push;
  logic             pop;
  logic             has_room;

  assign inst_valid = (count != '0);
  assign inst_out   = inst_valid ? head.inst : '0;
  assign inst_pc    = inst_valid ? head.pc : '0;

  // Request lines come only from registered state.
  assign imem_req  = (state != IDLE);
  assign imem_addr = imem_req ? req_addr : '0;

  assign pop      = inst_valid & ~stall & ~redirect;
  assign push     = (state == WAIT) & imem_ack & ~redirect;
  assign has_room = (count < FULL);
  assign post_cnt = count + CNT_W'(1) - CNT_W'(pop);
  assign wr_entry = '{pc: req_addr, inst: imem_rdata};

  inst_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (head),
    .count   (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= '0;
    end else begin
      if (redirect)  fetch_pc <= redirect_pc;
      else if (push) fetch_pc <= fetch_pc + 16'd1;
      unique case (state)
        IDLE: begin
          if (!redirect && has_room) begin
            state    <= WAIT;
            req_addr <= fetch_pc;
          end
        end
        WAIT: begin
          // A pending request cannot be withdrawn: park in DROP.
          if (redirect) begin
            state <= imem_ack ? IDLE : DROP;
          end else if (imem_ack) begin
            if (post_cnt < FULL) req_addr <= fetch_pc + 16'd1;
            else                 state    <= IDLE;
          end
        end
        DROP: begin
          if (imem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random checks of fetch_queue
// against a transaction-level model of the decode-visible stream.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [15:0] RPC   = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        stall = 1'b0;
  logic        inst_valid;
  logic [15:0] inst_out;
  logic [15:0] inst_pc;

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc)
  );

  // Memory: ack after a configurable number of req cycles.
  int lat_cfg  = 1;
  bit rand_lat = 1'b0;
  int rl       = 1;
  int mcnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt <= 0;
    end else if (imem_ack) begin
      mcnt <= 0;
      rl   <= $urandom_range(1, 3);
    end else if (imem_req) begin
      mcnt <= mcnt + 1;
    end
  end

  assign imem_ack   = imem_req && (mcnt >= (rand_lat ? rl : lat_cfg) - 1);
  assign imem_rdata = imem_ack ? (imem_addr ^ 16'hA5A5) : 16'h0;

  // Model: addresses fetched but not yet consumed by decode.
  logic [15:0] q[$];
  logic [15:0] fetch_exp;
  logic [15:0] prev_addr;
  bit          stale;
  bit          prev_hold;
  int          checks = 0;
  int          errors = 0;
  int          n;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    q.delete();
    fetch_exp = RPC;
    stale     = 1'b0;
    prev_hold = 1'b0;
  endtask

  task automatic cyc();
    bit good;
    bit pop;
    @(negedge clk);
    chk("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("inst_pc", 32'(inst_pc), 32'(q[0]));
      chk("inst_out", 32'(inst_out), 32'(q[0] ^ 16'hA5A5));
    end else begin
      chk("empty_pc", 32'(inst_pc), 32'h0);
      chk("empty_out", 32'(inst_out), 32'h0);
    end
    if (prev_hold) begin
      chk("req_hold", 32'(imem_req), 32'h1);
      chk("addr_hold", 32'(imem_addr), 32'(prev_addr));
    end
    good = imem_ack && !stale && !redirect;
    if (good) chk("fetch_addr", 32'(imem_addr), 32'(fetch_exp));
    pop = (q.size() != 0) && !stall && !redirect;
    prev_hold = imem_req && !imem_ack;
    prev_addr = imem_addr;
    if (imem_ack) stale = 1'b0;
    if (redirect) begin
      q.delete();
      fetch_exp = redirect_pc;
      if (imem_req && !imem_ack) stale = 1'b1;
    end else begin
      if (pop) void'(q.pop_front());
      if (good) begin
        q.push_back(imem_addr);
        fetch_exp++;
      end
    end
    chk("occupancy", 32'(q.size() <= DEPTH), 32'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mreset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_out", 32'(inst_out), 32'h0);
    chk("rst_pc", 32'(inst_pc), 32'h0);
    rst = 1'b0;
    mreset();

    // Zero-wait streaming
    cyc();
    chk("first_req", 32'(imem_req), 32'h1);
    chk("first_addr", 32'(imem_addr), 32'(RPC));
    chk("first_valid", 32'(inst_valid), 32'h0);
    cyc();
    chk("s0_valid", 32'(inst_valid), 32'h1);
    chk("s0_pc", 32'(inst_pc), 32'h0);
    chk("s0_out", 32'(inst_out), 32'hA5A5);
    cyc();
    chk("s1_pc", 32'(inst_pc), 32'h1);
    cyc();
    chk("s2_pc", 32'(inst_pc), 32'h2);

    // Stall until full
    stall = 1'b1;
    repeat (10) cyc();
    chk("full_count", 32'(q.size()), 32'(DEPTH));
    chk("full_req", 32'(imem_req), 32'h0);
    chk("full_valid", 32'(inst_valid), 32'h1);
    stall = 1'b0;
    repeat (8) cyc();

    // Redirect during the second wait cycle of a slow memory
    lat_cfg = 3;
    do_reset();
    cyc();
    cyc();
    chk("wait2_req", 32'(imem_req), 32'h1);
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    cyc();
    redirect = 1'b0;
    chk("drop_req", 32'(imem_req), 32'h1);
    chk("drop_addr", 32'(imem_addr), 32'h0);
    n = 0;
    while (imem_req && n < 10) begin cyc(); n++; end
    n = 0;
    while (!imem_req && n < 10) begin cyc(); n++; end
    chk("redir_req", 32'(imem_req), 32'h1);
    chk("redir_addr", 32'(imem_addr), 32'h0040);
    n = 0;
    while (!inst_valid && n < 20) begin cyc(); n++; end
    chk("redir_first_pc", 32'(inst_pc), 32'h0040);

    // Redirect coincident with an ack
    lat_cfg = 1;
    do_reset();
    repeat (4) cyc();
    chk("coinc_ack", 32'(imem_ack), 32'h1);
    redirect    = 1'b1;
    redirect_pc = 16'h1234;
    cyc();
    redirect = 1'b0;
    chk("coinc_valid", 32'(inst_valid), 32'h0);
    n = 0;
    while (!inst_valid && n < 20) begin cyc(); n++; end
    chk("coinc_pc", 32'(inst_pc), 32'h1234);

    // PC wrap
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    cyc();
    redirect = 1'b0;
    n = 0;
    while (!inst_valid && n < 20) begin cyc(); n++; end
    chk("wrap0", 32'(inst_pc), 32'hFFFE);
    cyc();
    chk("wrap1", 32'(inst_pc), 32'hFFFF);
    cyc();
    chk("wrap2", 32'(inst_pc), 32'h0000);

    // Asynchronous reset with two entries queued and a request pending
    lat_cfg = 2;
    stall   = 1'b1;
    do_reset();
    n = 0;
    while (!(q.size() == 2 && imem_req) && n < 30) begin cyc(); n++; end
    chk("pre_rst_cnt", 32'(q.size()), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", 32'(imem_req), 32'h0);
    chk("arst_addr", 32'(imem_addr), 32'h0);
    chk("arst_valid", 32'(inst_valid), 32'h0);
    chk("arst_out", 32'(inst_out), 32'h0);
    chk("arst_pc", 32'(inst_pc), 32'h0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    stall = 1'b0;
    mreset();
    cyc();
    chk("post_rst_req", 32'(imem_req), 32'h1);
    chk("post_rst_addr", 32'(imem_addr), 32'(RPC));

    // Random traffic
    rand_lat = 1'b1;
    for (int i = 0; i < 400; i++) begin
      stall    = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 16'hFFFD;
      else                           redirect_pc = 16'($urandom);
      cyc();
    end
    redirect = 1'b0;
    stall    = 1'b0;
    repeat (10) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
